// File: rtl/weight_load_ctrl.sv
// Weight-load controller: gathers a KSIZE^3 weight stream into per-lane write triplets,
// then replays the kernel's (row, col) grid as per-lane read addresses on request.
module weight_load_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 3,
    parameter int KSIZE      = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_start,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic                         scan_start,
    output logic                         mem_we,
    output logic [KSIZE*ADDR_W-1:0]      mem_row_wr,
    output logic [KSIZE*ADDR_W-1:0]      mem_col_wr,
    output logic [KSIZE*ADDR_W-1:0]      mem_ch_wr,
    output logic [KSIZE*DATA_WIDTH-1:0]  mem_wdata,
    output logic [KSIZE*ADDR_W-1:0]      mem_row_rd,
    output logic [KSIZE*ADDR_W-1:0]      mem_col_rd,
    output logic [KSIZE*ADDR_W-1:0]      mem_ch_rd,
    output logic                         rd_valid,
    output logic                         rd_last,
    output logic                         loaded,
    output logic                         busy
);
    typedef enum logic [1:0] {IDLE, LOAD, LOADED, SCAN} state_t;

    localparam logic [ADDR_W-1:0] KMAX = ADDR_W'(KSIZE - 1);

    state_t                        state_q;
    logic [ADDR_W-1:0]             row_q, col_q, ch_q;
    logic [DATA_WIDTH-1:0]         lane_q [KSIZE-1];
    logic                          mem_we_q;
    logic [KSIZE*ADDR_W-1:0]       wr_row_q, wr_col_q, wr_ch_q;
    logic [KSIZE*ADDR_W-1:0]       wr_row_d, wr_col_d, wr_ch_d;
    logic [KSIZE*DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                          rd_valid_q, rd_last_q;
    logic [ADDR_W-1:0]             rd_row_q, rd_col_q, rd_row_d, rd_col_d;

    // Write triplet as it will be registered on the last-channel handshake.
    always_comb begin
        wr_row_d = '0;
        wr_col_d = '0;
        wr_ch_d  = '0;
        wdata_d  = '0;
        for (int i = 0; i < KSIZE; i++) begin
            wr_row_d[i*ADDR_W +: ADDR_W] = row_q;
            wr_col_d[i*ADDR_W +: ADDR_W] = col_q;
            wr_ch_d[i*ADDR_W +: ADDR_W]  = ADDR_W'(i);
        end
        for (int i = 0; i < KSIZE - 1; i++)
            wdata_d[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[i];
        wdata_d[(KSIZE-1)*DATA_WIDTH +: DATA_WIDTH] = s_data;
    end

    always_comb begin
        rd_row_d = rd_row_q;
        rd_col_d = rd_col_q + ADDR_W'(1);
        if (rd_col_q == KMAX) begin
            rd_row_d = rd_row_q + ADDR_W'(1);
            rd_col_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            ch_q       <= '0;
            for (int i = 0; i < KSIZE - 1; i++) lane_q[i] <= '0;
            mem_we_q   <= 1'b0;
            wr_row_q   <= '0;
            wr_col_q   <= '0;
            wr_ch_q    <= '0;
            wdata_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_row_q   <= '0;
            rd_col_q   <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_q <= LOAD;
                        row_q   <= '0;
                        col_q   <= '0;
                        ch_q    <= '0;
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        if (ch_q == KMAX) begin
                            mem_we_q <= 1'b1;
                            wr_row_q <= wr_row_d;
                            wr_col_q <= wr_col_d;
                            wr_ch_q  <= wr_ch_d;
                            wdata_q  <= wdata_d;
                            // Final triplet holds the counters; only a new load clears them.
                            if (col_q == KMAX) begin
                                if (row_q == KMAX) begin
                                    state_q <= LOADED;
                                end else begin
                                    row_q <= row_q + ADDR_W'(1);
                                    col_q <= '0;
                                    ch_q  <= '0;
                                end
                            end else begin
                                col_q <= col_q + ADDR_W'(1);
                                ch_q  <= '0;
                            end
                        end else begin
                            for (int i = 0; i < KSIZE - 1; i++)
                                if (ch_q == ADDR_W'(i)) lane_q[i] <= s_data;
                            ch_q <= ch_q + ADDR_W'(1);
                        end
                    end
                end
                LOADED: begin
                    if (load_start) begin
                        state_q <= LOAD;
                        row_q   <= '0;
                        col_q   <= '0;
                        ch_q    <= '0;
                    end else if (scan_start) begin
                        state_q    <= SCAN;
                        rd_valid_q <= 1'b1;
                        rd_row_q   <= '0;
                        rd_col_q   <= '0;
                        rd_last_q  <= (KMAX == '0);
                    end
                end
                SCAN: begin
                    if (rd_last_q) begin
                        state_q    <= LOADED;
                        rd_valid_q <= 1'b0;
                        rd_last_q  <= 1'b0;
                        rd_row_q   <= '0;
                        rd_col_q   <= '0;
                    end else begin
                        rd_row_q  <= rd_row_d;
                        rd_col_q  <= rd_col_d;
                        rd_last_q <= (rd_row_d == KMAX) && (rd_col_d == KMAX);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_row_rd = '0;
        mem_col_rd = '0;
        mem_ch_rd  = '0;
        for (int i = 0; i < KSIZE; i++) begin
            mem_row_rd[i*ADDR_W +: ADDR_W] = rd_valid_q ? rd_row_q : '0;
            mem_col_rd[i*ADDR_W +: ADDR_W] = rd_valid_q ? rd_col_q : '0;
            mem_ch_rd[i*ADDR_W +: ADDR_W]  = rd_valid_q ? ADDR_W'(i) : '0;
        end
    end

    assign s_ready    = (state_q == LOAD);
    assign loaded     = (state_q == LOADED) || (state_q == SCAN);
    assign busy       = (state_q == LOAD) || (state_q == SCAN);
    assign mem_we     = mem_we_q;
    assign mem_row_wr = wr_row_q;
    assign mem_col_wr = wr_col_q;
    assign mem_ch_wr  = wr_ch_q;
    assign mem_wdata  = wdata_q;
    assign rd_valid   = rd_valid_q;
    assign rd_last    = rd_last_q;
endmodule

// File: tb/tb_weight_load_ctrl.sv
// Scoreboard bench for weight_load_ctrl: stimulus pushes expected writes/reads,
// a negedge monitor pops and compares whenever mem_we or rd_valid is seen.
module tb_weight_load_ctrl;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int K  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_start = 1'b0, s_valid = 1'b0, scan_start = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic s_ready, mem_we, rd_valid, rd_last, loaded, busy;
    logic [K*AW-1:0] mem_row_wr, mem_col_wr, mem_ch_wr, mem_row_rd, mem_col_rd, mem_ch_rd;
    logic [K*DW-1:0] mem_wdata;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [AW-1:0]   row;
        logic [AW-1:0]   col;
        logic [K*DW-1:0] data;
    } wr_t;
    typedef struct packed {
        logic [AW-1:0] row;
        logic [AW-1:0] col;
        logic          last;
    } rd_t;

    wr_t wq[$];
    rd_t rq[$];

    always #5 clk = ~clk;

    weight_load_ctrl #(.DATA_WIDTH(DW), .ADDR_W(AW), .KSIZE(K)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .scan_start(scan_start), .mem_we(mem_we),
        .mem_row_wr(mem_row_wr), .mem_col_wr(mem_col_wr), .mem_ch_wr(mem_ch_wr),
        .mem_wdata(mem_wdata),
        .mem_row_rd(mem_row_rd), .mem_col_rd(mem_col_rd), .mem_ch_rd(mem_ch_rd),
        .rd_valid(rd_valid), .rd_last(rd_last), .loaded(loaded), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [K*AW-1:0] rep(input logic [AW-1:0] v);
        logic [K*AW-1:0] b;
        for (int i = 0; i < K; i++) b[i*AW +: AW] = v;
        return b;
    endfunction

    function automatic logic [K*AW-1:0] chbus();
        logic [K*AW-1:0] b;
        for (int i = 0; i < K; i++) b[i*AW +: AW] = AW'(i);
        return b;
    endfunction

    // Monitor: compare against the scoreboard whenever the DUT presents an output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                if (wq.size() == 0) begin
                    chk("we_extra", 64'(mem_we), 64'd0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_row", 64'(mem_row_wr), 64'(rep(e.row)));
                    chk("wr_col", 64'(mem_col_wr), 64'(rep(e.col)));
                    chk("wr_ch", 64'(mem_ch_wr), 64'(chbus()));
                    chk("wr_data", 64'(mem_wdata), 64'(e.data));
                end
            end
            if (rd_valid) begin
                if (rq.size() == 0) begin
                    chk("rd_extra", 64'(rd_valid), 64'd0);
                end else begin
                    rd_t r;
                    r = rq.pop_front();
                    chk("rd_row", 64'(mem_row_rd), 64'(rep(r.row)));
                    chk("rd_col", 64'(mem_col_rd), 64'(rep(r.col)));
                    chk("rd_ch", 64'(mem_ch_rd), 64'(chbus()));
                    chk("rd_last", 64'(rd_last), 64'(r.last));
                    chk("rd_loaded", 64'(loaded), 64'd1);
                end
            end else begin
                chk("rd_idle_zero", 64'({mem_row_rd, mem_col_rd, mem_ch_rd, rd_last}), 64'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_writes(input int ntrip);
        for (int t = 0; t < ntrip; t++) begin
            wr_t e;
            e.row  = AW'(t / 3);
            e.col  = AW'(t % 3);
            e.data = {8'(3*t + 3), 8'(3*t + 2), 8'(3*t + 1)};
            wq.push_back(e);
        end
    endtask

    // Send beats 1..nbeats; optional idle cycle between beats.
    task automatic send_beats(input int nbeats, input bit gaps);
        for (int n = 0; n < nbeats; n++) begin
            s_valid = 1'b1;
            s_data  = 8'(n + 1);
            cyc();
            if (gaps) begin
                s_valid = 1'b0;
                s_data  = 8'hEE;
                cyc();
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic full_load(input bit gaps);
        push_writes(9);
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        chk("load_s_ready", 64'(s_ready), 64'd1);
        chk("load_loaded0", 64'(loaded), 64'd0);
        send_beats(27, gaps);
        chk("done_loaded", 64'(loaded), 64'd1);
        chk("done_s_ready", 64'(s_ready), 64'd0);
        chk("done_busy", 64'(busy), 64'd0);
        cyc();
        cyc();
        chk("wq_drained", 64'(wq.size()), 64'd0);
    endtask

    task automatic scan(input bit poke_load);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                rd_t e;
                e.row = AW'(r);
                e.col = AW'(c);
                e.last = (r == 2) && (c == 2);
                rq.push_back(e);
            end
        scan_start = 1'b1;
        cyc();
        scan_start = 1'b0;
        for (int i = 0; i < 20 && rq.size() != 0; i++) begin
            load_start = poke_load && (i == 2);
            cyc();
        end
        load_start = 1'b0;
        chk("rq_drained", 64'(rq.size()), 64'd0);
        chk("scan_loaded", 64'(loaded), 64'd1);
        chk("scan_busy", 64'(busy), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 64'({s_ready, mem_we, rd_valid, rd_last, loaded, busy}), 64'd0);
        chk({tag, "_wr"}, 64'({mem_row_wr, mem_col_wr, mem_ch_wr}), 64'd0);
        chk({tag, "_wd"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_rd"}, 64'({mem_row_rd, mem_col_rd, mem_ch_rd}), 64'd0);
    endtask

    initial begin
        #2;
        chk_all_zero("reset");
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // scan_start in IDLE is ignored
        scan_start = 1'b1;
        cyc();
        scan_start = 1'b0;
        cyc();
        chk("idle_scan_busy", 64'(busy), 64'd0);
        chk("idle_scan_loaded", 64'(loaded), 64'd0);

        full_load(1'b0);
        scan(1'b0);
        scan(1'b1);
        full_load(1'b1);
        scan(1'b0);

        // load_start and scan_start together in LOADED: load wins
        load_start = 1'b1;
        scan_start = 1'b1;
        cyc();
        load_start = 1'b0;
        scan_start = 1'b0;
        chk("both_busy", 64'(busy), 64'd1);
        chk("both_loaded", 64'(loaded), 64'd0);
        chk("both_s_ready", 64'(s_ready), 64'd1);

        // 14 beats then reset mid-load
        push_writes(4);
        send_beats(14, 1'b0);
        chk("partial_wq", 64'(wq.size()), 64'd0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midload_rst");
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        scan_start = 1'b1;
        cyc();
        scan_start = 1'b0;
        cyc();
        cyc();
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_loaded", 64'(loaded), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
